// File: rtl/wb_gpio_led.sv
// Wishbone B3 classic GPIO/LED slave: output, direction, LED and interrupt mask
// registers, synchronized header inputs with rising-edge status capture.
module wb_gpio_led #(
    parameter int                   GPIO_WIDTH = 8,
    parameter int                   LED_WIDTH  = 3,
    parameter logic [LED_WIDTH-1:0] LED_RESET  = '0
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    input  logic [4:0]            wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_oe_o,
    output logic [LED_WIDTH-1:0]  led_o,
    output logic                  irq_o
);

    localparam logic [2:0] ADR_OUT    = 3'd0;
    localparam logic [2:0] ADR_DIR    = 3'd1;
    localparam logic [2:0] ADR_IN     = 3'd2;
    localparam logic [2:0] ADR_LED    = 3'd3;
    localparam logic [2:0] ADR_MASK   = 3'd4;
    localparam logic [2:0] ADR_STATUS = 3'd5;

    logic [2:0]            reg_adr;
    logic                  req;
    logic                  wr;
    logic [31:0]           rdata;

    logic [GPIO_WIDTH-1:0] out_q;
    logic [GPIO_WIDTH-1:0] dir_q;
    logic [LED_WIDTH-1:0]  led_q;
    logic [GPIO_WIDTH-1:0] mask_q;
    logic [GPIO_WIDTH-1:0] status_q;
    logic [GPIO_WIDTH-1:0] sync1_q;
    logic [GPIO_WIDTH-1:0] sync2_q;
    logic [GPIO_WIDTH-1:0] prev_q;
    logic [GPIO_WIDTH-1:0] rise;
    logic [GPIO_WIDTH-1:0] clr;
    logic                  irq_q;

    // Handshake: a request is cyc & stb while ack is low; it is answered on
    // the same edge with ack=1 and registered read data, and ack is forced
    // low on the following edge, so a held strobe is served every other cycle.
    assign reg_adr = wb_adr_i[4:2];
    assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr      = req & wb_we_i & wb_sel_i[0];

    always_comb begin
        rdata = '0;
        case (reg_adr)
            ADR_OUT:    rdata[GPIO_WIDTH-1:0] = out_q;
            ADR_DIR:    rdata[GPIO_WIDTH-1:0] = dir_q;
            ADR_IN:     rdata[GPIO_WIDTH-1:0] = sync2_q;
            ADR_LED:    rdata[LED_WIDTH-1:0]  = led_q;
            ADR_MASK:   rdata[GPIO_WIDTH-1:0] = mask_q;
            ADR_STATUS: rdata[GPIO_WIDTH-1:0] = status_q;
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= req;
            if (req) begin
                wb_dat_o <= rdata;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            out_q  <= '0;
            dir_q  <= '0;
            led_q  <= LED_RESET;
            mask_q <= '0;
        end else if (wr) begin
            case (reg_adr)
                ADR_OUT:  out_q  <= wb_dat_i[GPIO_WIDTH-1:0];
                ADR_DIR:  dir_q  <= wb_dat_i[GPIO_WIDTH-1:0];
                ADR_LED:  led_q  <= wb_dat_i[LED_WIDTH-1:0];
                ADR_MASK: mask_q <= wb_dat_i[GPIO_WIDTH-1:0];
                default:  ;
            endcase
        end
    end

    // Pins are sampled regardless of direction, so driven pins also capture edges.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= gpio_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~prev_q;
    assign clr  = (wr && reg_adr == ADR_STATUS) ? wb_dat_i[GPIO_WIDTH-1:0] : '0;

    // A fresh edge beats a write-1-to-clear of the same bit in the same cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= (status_q & ~clr) | rise;
            irq_q    <= |(status_q & mask_q);
        end
    end

    assign gpio_o    = out_q;
    assign gpio_oe_o = dir_q;
    assign led_o     = led_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_wb_gpio_led.sv
// Directed bench for wb_gpio_led: register access, ack timing, edge capture,
// interrupt latency and asynchronous reset.
module tb_wb_gpio_led;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  wb_adr;
    logic [31:0] wb_dat_w;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic [31:0] wb_dat_r;
    logic        wb_ack;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic [2:0]  led;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;
    logic        ack_seq [6];

    wb_gpio_led #(
        .GPIO_WIDTH(8),
        .LED_WIDTH (3),
        .LED_RESET (3'b101)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_n_i(rst_n),
        .wb_adr_i  (wb_adr),
        .wb_dat_i  (wb_dat_w),
        .wb_sel_i  (wb_sel),
        .wb_we_i   (wb_we),
        .wb_cyc_i  (wb_cyc),
        .wb_stb_i  (wb_stb),
        .wb_dat_o  (wb_dat_r),
        .wb_ack_o  (wb_ack),
        .gpio_i    (gpio_in),
        .gpio_o    (gpio_out),
        .gpio_oe_o (gpio_oe),
        .led_o     (led),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns #1 after the acknowledging edge, with the strobe already dropped.
    task automatic wb_xfer(input logic [4:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] data);
        int n;
        @(negedge clk);
        wb_adr   = adr;
        wb_we    = we;
        wb_dat_w = dat;
        wb_sel   = sel;
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wb_ack && n < 8);
        check("xfer_ack", {31'd0, wb_ack}, 32'd1);
        data   = wb_dat_r;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        wb_adr   = '0;
        wb_dat_w = '0;
        wb_sel   = '0;
        wb_we    = 1'b0;
        wb_cyc   = 1'b0;
        wb_stb   = 1'b0;
        gpio_in  = '0;
        #12;
        check("rst_led", {29'd0, led}, 32'h5);
        check("rst_oe", {24'd0, gpio_oe}, 32'h0);
        check("rst_gpio_o", {24'd0, gpio_out}, 32'h0);
        check("rst_ack", {31'd0, wb_ack}, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        check("rst_dat", wb_dat_r, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // LED read and single-cycle ack
        wb_xfer(5'h0C, 1'b0, 32'h0, 4'hF, rd);
        check("rd_led", rd, 32'h5);
        idle(1);
        check("ack_one_cycle", {31'd0, wb_ack}, 32'h0);

        // OUT/DIR writes visible from the ack cycle
        wb_xfer(5'h00, 1'b1, 32'hFFFF_FFA5, 4'h1, rd);
        check("gpio_o_ack", {24'd0, gpio_out}, 32'hA5);
        wb_xfer(5'h04, 1'b1, 32'h0000_00F0, 4'h1, rd);
        check("gpio_oe_ack", {24'd0, gpio_oe}, 32'hF0);
        wb_xfer(5'h00, 1'b0, 32'h0, 4'hF, rd);
        check("rd_out", rd, 32'hA5);
        wb_xfer(5'h04, 1'b0, 32'h0, 4'hF, rd);
        check("rd_dir", rd, 32'hF0);

        // sel[0]=0 write is acked but ignored; sel[0]=1 updates LED
        wb_xfer(5'h0C, 1'b1, 32'h0000_0002, 4'hE, rd);
        check("led_sel_ignored", {29'd0, led}, 32'h5);
        wb_xfer(5'h0C, 1'b1, 32'hFFFF_FFFA, 4'h1, rd);
        check("led_write", {29'd0, led}, 32'h2);
        wb_xfer(5'h0C, 1'b0, 32'h0, 4'hF, rd);
        check("rd_led_zext", rd, 32'h2);

        // Edge capture and interrupt latency
        wb_xfer(5'h10, 1'b1, 32'h0000_0001, 4'h1, rd);
        wb_xfer(5'h10, 1'b0, 32'h0, 4'hF, rd);
        check("rd_mask", rd, 32'h01);
        idle(2);
        @(negedge clk);
        gpio_in = 8'h81;
        idle(3);
        check("irq_edge3", {31'd0, irq}, 32'h0);
        idle(1);
        check("irq_edge4", {31'd0, irq}, 32'h1);
        wb_xfer(5'h08, 1'b0, 32'h0, 4'hF, rd);
        check("rd_in", rd, 32'h81);
        wb_xfer(5'h14, 1'b0, 32'h0, 4'hF, rd);
        check("rd_status", rd, 32'h81);

        // Clear of bit0 on the same edge as a new rise on bit0: the rise wins
        @(negedge clk);
        gpio_in = 8'h80;
        idle(4);
        @(negedge clk);
        gpio_in = 8'h81;
        @(negedge clk);
        wb_xfer(5'h14, 1'b1, 32'h0000_0001, 4'h1, rd);
        wb_xfer(5'h14, 1'b0, 32'h0, 4'hF, rd);
        check("status_rise_wins", rd, 32'h81);

        // Full clear drops irq one cycle later
        wb_xfer(5'h14, 1'b1, 32'h0000_0081, 4'h1, rd);
        check("irq_before_drop", {31'd0, irq}, 32'h1);
        idle(1);
        check("irq_after_clear", {31'd0, irq}, 32'h0);
        wb_xfer(5'h14, 1'b0, 32'h0, 4'hF, rd);
        check("status_cleared", rd, 32'h0);

        // Held strobe: ack every other cycle; unused addresses read 0
        idle(1);
        @(negedge clk);
        wb_adr = 5'h00;
        wb_we  = 1'b0;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            ack_seq[i] = wb_ack;
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        check("ack_pattern", {26'd0, ack_seq[0], ack_seq[1], ack_seq[2],
                              ack_seq[3], ack_seq[4], ack_seq[5]}, 32'b101010);
        idle(1);
        wb_xfer(5'h1C, 1'b1, 32'hFFFF_FFFF, 4'hF, rd);
        wb_xfer(5'h18, 1'b0, 32'h0, 4'hF, rd);
        check("rd_unused", rd, 32'h0);
        wb_xfer(5'h1C, 1'b0, 32'h0, 4'hF, rd);
        check("rd_unused_after_wr", rd, 32'h0);

        // Stb without cyc is ignored
        @(negedge clk);
        wb_stb = 1'b1;
        idle(2);
        check("stb_no_cyc", {31'd0, wb_ack}, 32'h0);
        wb_stb = 1'b0;

        // Asynchronous reset while ack is high and outputs are set
        @(negedge clk);
        gpio_in = 8'h80;
        idle(4);
        @(negedge clk);
        gpio_in = 8'h81;
        idle(5);
        check("irq_pre_reset", {31'd0, irq}, 32'h1);
        wb_xfer(5'h00, 1'b0, 32'h0, 4'hF, rd);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_ack", {31'd0, wb_ack}, 32'h0);
        check("async_gpio_o", {24'd0, gpio_out}, 32'h0);
        check("async_oe", {24'd0, gpio_oe}, 32'h0);
        check("async_irq", {31'd0, irq}, 32'h0);
        check("async_led", {29'd0, led}, 32'h5);
        gpio_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        wb_xfer(5'h10, 1'b0, 32'h0, 4'hF, rd);
        check("mask_after_reset", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_gpio_led.md
Name: wb_gpio_led

Overview:
- Wishbone B3 classic slave on the SoC peripheral bus, in the `wb_clk` domain.
- Consumes bus cycles from the picorv32 Wishbone interconnect.
- Drives the board LED pins and the bidirectional IO header. Pin tristating is done outside the block.
- Samples header inputs, latches rising edges and raises a maskable level interrupt to the core.

Parameters:
- GPIO_WIDTH, 8, number of IO header pins (1..8).
- LED_WIDTH, 3, number of LED outputs (1..8).
- LED_RESET, 0, LED register value after reset.

Ports:
- wb_clk_i  in  1  bus clock; the only clock.
- wb_rst_n_i  in  1  reset, asynchronous, active-low; clears all state immediately.
- wb_adr_i  in  5  byte address; decode uses [4:2] only.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte selects; only [0] is used.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_dat_o  out  32  registered read data.
- wb_ack_o  out  1  single-cycle acknowledge.
- gpio_i  in  GPIO_WIDTH  raw asynchronous pin inputs.
- gpio_o  out  GPIO_WIDTH  pin output values.
- gpio_oe_o  out  GPIO_WIDTH  per-pin output enable, 1 = drive.
- led_o  out  LED_WIDTH  LED drive.
- irq_o  out  1  level interrupt.

Behaviour:
- Reset state:
  - wb_ack_o=0, wb_dat_o=0, gpio_o=0, gpio_oe_o=0, led_o=LED_RESET, irq_o=0.
  - Sync flops, edge-detect flop, MASK and STATUS all 0.
- Register map (adr[4:2]):
  - 0 OUT: rw.
  - 1 DIR: rw.
  - 2 IN: ro, synchronized pins.
  - 3 LED: rw.
  - 4 MASK: rw.
  - 5 STATUS: read; write-1-to-clear.
  - 6,7: read 0, writes ignored, still acked.
  - Unused upper bits read 0.
- Handshake:
  - At a clock edge where cyc & stb & !ack: ack<=1 and dat_o<=selected register.
  - If we & sel[0] on that same edge, the register write takes effect there. The new value appears on outputs on the ack cycle.
  - Next edge ack<=0, so a held strobe is acked every other cycle.
  - Writes with sel[0]=0 are acked and change nothing.
  - Read latency: 1 cycle.
  - stb without cyc is ignored.
- Reset mid-cycle: ack drops asynchronously. Any write not yet clocked is lost.
- Input path:
  - Two-flop synchronizer s1→s2.
  - IN reads s2, so a pin change is readable in IN 2 edges later.
  - Edge flop p<=s2; rise = s2 & ~p.
  - STATUS[i] is set on the edge after rise[i]: 3 edges after the pin change.
  - A pin held high through reset deassertion produces one rise 2 edges later. This is intended; MASK=0 keeps it silent.
- STATUS update: status <= (status & ~clr) | rise, where clr = wb_dat_i masked by a valid STATUS write. New edge wins over clear on the same bit and same cycle.
- irq_o: registered |(STATUS & MASK), one cycle after STATUS/MASK change.
- Output-direction pins: edge capture still runs on the read-back value.
- Widths: writes take wb_dat_i[GPIO_WIDTH-1:0] or [LED_WIDTH-1:0]. Reads zero-extend to 32 bits.

Test Plan:
- Reset with LED_RESET=3'b101, gpio_i=0 → led_o=101, gpio_oe_o=00, wb_ack_o=0, irq_o=0. Read adr 0x0C → dat_o=0x5, ack high exactly 1 cycle.
- Write 0xA5 to 0x00, write 0xF0 to 0x04 → gpio_o=A5, gpio_oe_o=F0 from the ack cycle. Readback 0x00=0xA5 and 0x04=0xF0. Write 0x0C with sel=4'b1110 → LED unchanged, ack still given.
- gpio_i 00→0x81 at edge n → IN reads 0x81 from edge n+2. STATUS=0x81 at n+3. With MASK=0x01, irq_o=1 at n+4.
- Write 0x01 to STATUS on the same cycle as a new rise on bit0 → STATUS[0] stays 1. Next write 0x81 without a rise → STATUS=0, irq_o=0 one cycle later.
- Hold cyc/stb for 6 cycles → ack pattern 1,0,1,0,1,0. Read 0x18 → 0, acked.
- Assert wb_rst_n_i low while ack=1 and outputs are set → ack, gpio_o, gpio_oe_o, irq_o clear with no clock edge.
